// File: rtl/anneal_controller.sv
// Run sequencer and spin readout for the coupled-oscillator core matrix.
// Holds the core in reset, lets it oscillate freely, then measures each
// oscillator's phase against oscillator 0 over a sample window. The result
// is latched as an N-bit spin vector.
module anneal_controller #(
    parameter int N           = 8,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             axi_rstn,
    input  logic             go,
    input  logic             abort,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic [CNT_W-1:0] sample_cycles,
    input  logic [N-1:0]     outputs,
    output logic             ising_rstn,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     spins
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RESET  = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RST_LEN = CNT_W'(RST_CYCLES);

    logic [2:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] run_len_r, run_len_s;
    logic [CNT_W-1:0] sample_len_r, sample_len_s;
    logic [CNT_W-1:0] mismatch_r [N];
    logic [CNT_W-1:0] mismatch_s [N];
    logic [N-1:0]     sync_r [SYNC_STAGES];
    logic [N-1:0]     sync_out_s;
    logic [N-1:0]     spins_r, spins_s;
    logic             ising_rstn_r, ising_rstn_s;
    logic             start_r, start_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             sample_last_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign ising_rstn = ising_rstn_r;
    assign start      = start_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign spins      = spins_r;

    // Multi-flop synchroniser bringing the asynchronous oscillator outputs into clk
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '0;
            end
        end else begin
            sync_r[0] <= outputs;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Sequencer next state, phase counter, captured lengths and mismatch accumulation
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r + ONE;
        run_len_s    = run_len_r;
        sample_len_s = sample_len_r;
        mismatch_s   = mismatch_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (go && !abort) begin
                    state_s      = ST_RESET;
                    run_len_s    = (run_cycles == '0) ? ONE : run_cycles;
                    sample_len_s = (sample_cycles == '0) ? ONE : sample_cycles;
                    for (int i = 0; i < N; i++) begin
                        mismatch_s[i] = '0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RESET: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else if (cnt_r == RST_LEN - ONE) begin
                    state_s = ST_RUN;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_RESET;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else if (cnt_r == run_len_r - ONE) begin
                    state_s = ST_SAMPLE;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_SAMPLE: begin
                // Count disagreements with oscillator 0 on every window cycle
                for (int i = 1; i < N; i++) begin
                    mismatch_s[i] = mismatch_r[i] +
                        {{(CNT_W-1){1'b0}}, sync_out_s[i] ^ sync_out_s[0]};
                end
                if (abort) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else if (sample_last_s) begin
                    state_s = ST_DONE;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_SAMPLE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    assign sample_last_s = (state_r == ST_SAMPLE) && (cnt_r == sample_len_r - ONE);

    // Spin decision: majority of window cycles out of phase; ties read as 0
    always_comb begin
        spins_s = spins_r;
        if (sample_last_s && !abort) begin
            for (int i = 1; i < N; i++) begin
                spins_s[i] = ({mismatch_s[i], 1'b0} > {1'b0, sample_len_r});
            end
            spins_s[0] = 1'b0;
        end else begin
            spins_s = spins_r;
        end
    end

    // Output decode from the next state so the port flops match the state register
    always_comb begin
        ising_rstn_s = 1'b0;
        start_s      = 1'b0;
        busy_s       = 1'b1;
        done_s       = 1'b0;
        case (state_s)
            ST_IDLE:   busy_s = 1'b0;
            ST_RESET:  busy_s = 1'b1;
            ST_RUN,
            ST_SAMPLE: begin
                ising_rstn_s = 1'b1;
                start_s      = 1'b1;
            end
            ST_DONE: begin
                ising_rstn_s = 1'b1;
                start_s      = 1'b1;
                done_s       = 1'b1;
            end
            default:   busy_s = 1'b0;
        endcase
    end

    // State, counters, captured lengths and registered outputs
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            run_len_r    <= '0;
            sample_len_r <= '0;
            for (int i = 0; i < N; i++) begin
                mismatch_r[i] <= '0;
            end
            spins_r      <= '0;
            ising_rstn_r <= 1'b0;
            start_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            run_len_r    <= run_len_s;
            sample_len_r <= sample_len_s;
            mismatch_r   <= mismatch_s;
            spins_r      <= spins_s;
            ising_rstn_r <= ising_rstn_s;
            start_r      <= start_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

endmodule

// File: doc/anneal_controller.md
Name: anneal_controller

Overview:
- Run sequencer and spin readout directly downstream of the coupled-oscillator core matrix.
- Drives the core's ising_rstn and start for a programmed number of cycles.
- Synchronises the core's N oscillator outputs and measures each one's phase against oscillator 0 over a sample window.
- Latches the resulting N-bit spin vector for software readback.

Parameters:
N, 8, number of oscillators/spins
CNT_W, 32, width of run/sample/mismatch counters
RST_CYCLES, 4, cycles ising_rstn held low before each run (>=1)
SYNC_STAGES, 2, flop stages synchronising outputs into clk domain (>=2)

Ports:
clk  input  1  system clock
axi_rstn  input  1  asynchronous active-low reset
go  input  1  single-cycle request to start a run; honoured only in IDLE
abort  input  1  terminates an active run; returns to IDLE, no done
run_cycles  input  CNT_W  cycles of free oscillation before sampling; 0 treated as 1
sample_cycles  input  CNT_W  sample window length; 0 treated as 1
outputs  input  N  asynchronous oscillator outputs from core matrix
ising_rstn  output  1  reset to core matrix, active-low
start  output  1  start/enable to core matrix
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when spins updated
spins  output  N  latched spin result; spins[0] always 0

Behaviour:
- Reset (axi_rstn low, any time, including mid-run): state=IDLE, ising_rstn=0, start=0, busy=0, done=0, spins=0, all counters=0, sync flops=0.
- Synchroniser: SYNC_STAGES flops per bit on outputs; all comparisons use the final stage (sync_out). The window is delayed by SYNC_STAGES; this is accepted.
- run_cycles and sample_cycles are captured on the go cycle; later changes have no effect on the active run.
- IDLE: ising_rstn=0, start=0. go=1 (and abort=0) -> RESET. Clear cnt, mismatch[*].
- RESET: ising_rstn=0, start=0. Lasts exactly RST_CYCLES cycles -> RUN.
- RUN: ising_rstn=1, start=1. Lasts exactly max(run_cycles,1) cycles -> SAMPLE.
- SAMPLE: ising_rstn=1, start=1. Lasts exactly max(sample_cycles,1) cycles.
  - Each cycle, for i in 1..N-1: mismatch[i] += (sync_out[i] != sync_out[0]).
  - Then -> DONE.
- DONE: one cycle.
  - ising_rstn=1, start=1, done=1.
  - spins[i] registered from the count including the final SAMPLE cycle: spins[i] = 1 iff 2*mismatch[i] > S, where S is the effective sample length. Tie gives 0.
  - spins[0]=0. New spins visible from the DONE cycle onward.
  - -> IDLE.
- Timing, with go seen at cycle 0, R=RST_CYCLES, T=effective run length, S=effective sample length:
  - RESET occupies cycles 1..R.
  - RUN occupies R+1..R+T.
  - SAMPLE occupies R+T+1..R+T+S.
  - done pulses at R+T+S+1; busy falls at R+T+S+2.
- go while busy: ignored, no queuing.
- abort=1 in RESET/RUN/SAMPLE: next cycle IDLE, ising_rstn=0, start=0, no done, spins keep their previous value.
- abort in DONE: ignored; the DONE cycle completes normally.
- go and abort together in IDLE: abort wins, stay IDLE.
- Arithmetic:
  - mismatch counters are CNT_W bits and cannot overflow, since mismatch <= S < 2^CNT_W.
  - The comparison uses a CNT_W+1-bit left-shifted mismatch.
- N=1: spins=0, sequence still runs and done pulses.

Test Plan:
- Reset value check: axi_rstn low mid-SAMPLE -> ising_rstn=0, start=0, busy=0, done=0, spins=0 immediately (async); after release, IDLE.
- Latency check: RST_CYCLES=4, run_cycles=10, sample_cycles=8, go at cycle 0 -> ising_rstn rises at cycle 5, done exactly at cycle 23, busy low at cycle 24.
- Phase decoding: N=4.
  - Stimulus: outputs[0] toggles every 2 cycles; outputs[1]=outputs[0]; outputs[2]=~outputs[0]; outputs[3] lags outputs[0] by a quarter period; sample_cycles=16.
  - Required: spins=4'b0100 (bit 3 tie/near-half gives 0).
- Zero lengths: run_cycles=0, sample_cycles=0, RST_CYCLES=4 -> RUN 1 cycle, SAMPLE 1 cycle, done at cycle 7. A single mismatch on bit 1 gives spins[1]=1.
- Abort: abort during RUN with previous spins=8'hA6 -> IDLE next cycle, no done pulse, spins remain 8'hA6, ising_rstn=0. A following go runs normally.
- go while busy: extra go pulses in RUN and SAMPLE, plus changed run_cycles -> exactly one done, timing matches the originally captured lengths.
